// File: rtl/imem_arbiter_pkg.sv
// Shared constants and types for the instruction-memory arbiter.
package imem_arbiter_pkg;

   localparam int unsigned DEF_ADDR_W     = 64;
   localparam int unsigned DEF_ROM_WORDS  = 1024;
   localparam int unsigned DEF_STARVE_LIM = 4;

   // Occupancy of a single-entry response slot.
   typedef enum logic {
      SlotEmpty = 1'b0,
      SlotFull  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/imem_arbiter_rsp_slot.sv
// Single-entry response buffer: holds one response until the consumer takes it.
module rsp_slot
   import imem_arbiter_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        load_i,
   input  logic [31:0] load_data_i,
   input  logic        load_err_i,
   input  logic        rsp_ready_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data_o,
   output logic        rsp_err_o,
   output logic        can_accept_o
);

   slot_state_e state;
   slot_state_e state_next;
   logic [31:0] data;
   logic        err;

   // Next state: flush wins, then load (also covers drain+load), then drain.
   always_comb begin
      state_next = state;
      if (flush_i) begin
         state_next = SlotEmpty;
      end else if (load_i) begin
         state_next = SlotFull;
      end else if (state == SlotFull && rsp_ready_i) begin
         state_next = SlotEmpty;
      end
   end

   // Slot occupancy register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= SlotEmpty;
      end else begin
         state <= state_next;
      end
   end

   // Payload only changes on load, so it stays stable while stalled.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data <= '0;
         err  <= 1'b0;
      end else if (load_i && !flush_i) begin
         data <= load_data_i;
         err  <= load_err_i;
      end
   end

   assign rsp_valid_o  = (state == SlotFull);
   assign rsp_data_o   = data;
   assign rsp_err_o    = err;
   // Room for a new response: empty now, or being emptied this cycle.
   assign can_accept_o = (state == SlotEmpty) || rsp_ready_i;

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter (fetch, data) in front of a combinational-read word ROM.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned ROM_WORDS  = DEF_ROM_WORDS,
   parameter int unsigned STARVE_LIM = DEF_STARVE_LIM
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              f_req_valid_i,
   output logic              f_req_ready_o,
   input  logic [ADDR_W-1:0] f_req_addr_i,
   input  logic              f_flush_i,
   output logic              f_rsp_valid_o,
   input  logic              f_rsp_ready_i,
   output logic [31:0]       f_rsp_data_o,
   output logic              f_rsp_err_o,
   input  logic              d_req_valid_i,
   output logic              d_req_ready_o,
   input  logic [ADDR_W-1:0] d_req_addr_i,
   output logic              d_rsp_valid_o,
   input  logic              d_rsp_ready_i,
   output logic [31:0]       d_rsp_data_o,
   output logic              d_rsp_err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [31:0]       mem_rdata_i
);

   localparam int unsigned CNT_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STARVE_LIM);
   localparam logic [ADDR_W-3:0] WORD_LIM = (ADDR_W - 2)'(ROM_WORDS);

   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_cnt_next;
   logic             f_elig;
   logic             contend;
   logic             f_win;
   logic             d_win;
   logic             f_can;
   logic             d_can;
   logic             f_acc;
   logic             d_acc;
   logic             illegal;
   logic [31:0]      ld_data;

   // Winner is chosen from request valids only, so neither req_ready depends
   // on the other port's rsp_ready.
   always_comb begin
      f_elig  = f_req_valid_i && !f_flush_i;
      contend = f_elig && d_req_valid_i;
      d_win   = d_req_valid_i && !(contend && starve_cnt == CNT_MAX);
      f_win   = f_elig && !d_win;
      f_req_ready_o = !rst_i && f_win && f_can;
      d_req_ready_o = !rst_i && d_win && d_can;
      f_acc = f_req_valid_i && f_req_ready_o;
      d_acc = d_req_valid_i && d_req_ready_o;
   end

   // ROM address mux and legality check for the accepted request.
   always_comb begin
      mem_addr_o = '0;
      if (d_acc) begin
         mem_addr_o = d_req_addr_i;
      end else if (f_acc) begin
         mem_addr_o = f_req_addr_i;
      end
      illegal = (mem_addr_o[1:0] != 2'b00) || (mem_addr_o[ADDR_W-1:2] >= WORD_LIM);
      ld_data = illegal ? 32'h0 : mem_rdata_i;
   end

   // Starvation counter: flush holds it, fetch grant or no contention clears it.
   always_comb begin
      starve_cnt_next = starve_cnt;
      if (f_flush_i) begin
         starve_cnt_next = starve_cnt;
      end else if (f_acc || !contend) begin
         starve_cnt_next = '0;
      end else if (d_acc && starve_cnt != CNT_MAX) begin
         starve_cnt_next = starve_cnt + 1'b1;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_cnt <= '0;
      end else begin
         starve_cnt <= starve_cnt_next;
      end
   end

   rsp_slot u_f_slot (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (f_flush_i),
      .load_i       (f_acc),
      .load_data_i  (ld_data),
      .load_err_i   (illegal),
      .rsp_ready_i  (f_rsp_ready_i),
      .rsp_valid_o  (f_rsp_valid_o),
      .rsp_data_o   (f_rsp_data_o),
      .rsp_err_o    (f_rsp_err_o),
      .can_accept_o (f_can)
   );

   rsp_slot u_d_slot (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (1'b0),
      .load_i       (d_acc),
      .load_data_i  (ld_data),
      .load_err_i   (illegal),
      .rsp_ready_i  (d_rsp_ready_i),
      .rsp_valid_o  (d_rsp_valid_o),
      .rsp_data_o   (d_rsp_data_o),
      .rsp_err_o    (d_rsp_err_o),
      .can_accept_o (d_can)
   );

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural 1024-word ROM.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_req_valid;
   logic        f_req_ready;
   logic [63:0] f_req_addr;
   logic        f_flush;
   logic        f_rsp_valid;
   logic        f_rsp_ready;
   logic [31:0] f_rsp_data;
   logic        f_rsp_err;
   logic        d_req_valid;
   logic        d_req_ready;
   logic [63:0] d_req_addr;
   logic        d_rsp_valid;
   logic        d_rsp_ready;
   logic [31:0] d_rsp_data;
   logic        d_rsp_err;
   logic [63:0] mem_addr;
   logic [31:0] mem_rdata;

   logic [31:0] rom [0:1023];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Out-of-range reads return a nonzero pattern so a missing error is visible.
   always_comb begin
      if (mem_addr[63:12] == '0) mem_rdata = rom[mem_addr[11:2]];
      else mem_rdata = 32'hDEAD_BEEF;
   end

   imem_arbiter dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .f_req_valid_i (f_req_valid),
      .f_req_ready_o (f_req_ready),
      .f_req_addr_i  (f_req_addr),
      .f_flush_i     (f_flush),
      .f_rsp_valid_o (f_rsp_valid),
      .f_rsp_ready_i (f_rsp_ready),
      .f_rsp_data_o  (f_rsp_data),
      .f_rsp_err_o   (f_rsp_err),
      .d_req_valid_i (d_req_valid),
      .d_req_ready_o (d_req_ready),
      .d_req_addr_i  (d_req_addr),
      .d_rsp_valid_o (d_rsp_valid),
      .d_rsp_ready_i (d_rsp_ready),
      .d_rsp_data_o  (d_rsp_data),
      .d_rsp_err_o   (d_rsp_err),
      .mem_addr_o    (mem_addr),
      .mem_rdata_i   (mem_rdata)
   );

   task automatic test_reset();
      rst = 1'b1;
      f_req_valid = 1'b1; f_req_addr = 64'h0; f_flush = 1'b0; f_rsp_ready = 1'b1;
      d_req_valid = 1'b1; d_req_addr = 64'h4; d_rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({f_req_ready, d_req_ready} !== 2'b00) begin
         errors++; $display("FAIL reset_req_ready: got %b expected 00", {f_req_ready, d_req_ready});
      end
      checks++;
      if (mem_addr !== 64'h0) begin
         errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr);
      end
      f_req_valid = 1'b0; d_req_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
      #1;
      checks++;
      if ({f_rsp_valid, d_rsp_valid, f_rsp_data, d_rsp_data, f_rsp_err, d_rsp_err} !== '0) begin
         errors++; $display("FAIL reset_outputs: got fv=%b dv=%b fd=%h dd=%h expected all 0",
                            f_rsp_valid, d_rsp_valid, f_rsp_data, d_rsp_data);
      end
   endtask

   task automatic test_fetch_only();
      logic [31:0] exp_w [0:2];
      exp_w[0] = 32'h0050_0093; exp_w[1] = 32'h00a0_0113; exp_w[2] = 32'h0020_81b3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         f_req_valid = 1'b1; f_req_addr = 64'(i * 4);
         #1;
         checks++;
         if (f_req_ready !== 1'b1 || mem_addr !== 64'(i * 4)) begin
            errors++; $display("FAIL fetch_accept[%0d]: got rdy=%b addr=%h expected 1 %h",
                               i, f_req_ready, mem_addr, i * 4);
         end
         @(posedge clk); #1;
         checks++;
         if (f_rsp_valid !== 1'b1 || f_rsp_data !== exp_w[i] || f_rsp_err !== 1'b0) begin
            errors++; $display("FAIL fetch_rsp[%0d]: got v=%b d=%h e=%b expected 1 %h 0",
                               i, f_rsp_valid, f_rsp_data, f_rsp_err, exp_w[i]);
         end
      end
      @(negedge clk); f_req_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (f_rsp_valid !== 1'b0) begin
         errors++; $display("FAIL fetch_drain: got v=%b expected 0", f_rsp_valid);
      end
   endtask

   task automatic test_starvation();
      logic [1:0] got;
      logic [1:0] exp;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         f_req_valid = 1'b1; f_req_addr = 64'hC;
         d_req_valid = 1'b1; d_req_addr = 64'h10;
         #1;
         got = {d_req_ready, f_req_ready};
         exp = (k % 5 == 4) ? 2'b01 : 2'b10;
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL starve_grant[%0d]: got {d,f}=%b expected %b", k, got, exp);
         end
      end
      @(negedge clk); f_req_valid = 1'b0; d_req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_illegal();
      logic [63:0] addrs [0:1];
      addrs[0] = 64'h2; addrs[1] = 64'h1000;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         d_req_valid = 1'b1; d_req_addr = addrs[i];
         @(posedge clk); #1;
         checks++;
         if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b1 || d_rsp_data !== 32'h0) begin
            errors++; $display("FAIL illegal[%0d]: got v=%b e=%b d=%h expected 1 1 0",
                               i, d_rsp_valid, d_rsp_err, d_rsp_data);
         end
      end
      @(negedge clk); d_req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      f_rsp_ready = 1'b0; f_req_valid = 1'b1; f_req_addr = 64'h4;
      @(posedge clk); #1;
      checks++;
      if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'h00a0_0113) begin
         errors++; $display("FAIL bp_first: got v=%b d=%h expected 1 00a00113", f_rsp_valid, f_rsp_data);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         f_req_addr = 64'h8; d_req_valid = 1'b1; d_req_addr = 64'h14;
         #1;
         checks++;
         if (f_req_ready !== 1'b0 || d_req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready[%0d]: got f=%b d=%b expected 0 1", k, f_req_ready, d_req_ready);
         end
         @(posedge clk); #1;
         checks++;
         if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'h00a0_0113 || d_rsp_valid !== 1'b1
             || d_rsp_data !== 32'hA500_0005) begin
            errors++; $display("FAIL bp_hold[%0d]: got fv=%b fd=%h dv=%b dd=%h expected 1 00a00113 1 a5000005",
                               k, f_rsp_valid, f_rsp_data, d_rsp_valid, d_rsp_data);
         end
      end
      @(negedge clk);
      d_req_valid = 1'b0; f_rsp_ready = 1'b1;
      #1;
      checks++;
      if (f_req_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release_ready: got %b expected 1", f_req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'h0020_81b3) begin
         errors++; $display("FAIL bp_reload: got v=%b d=%h expected 1 002081b3", f_rsp_valid, f_rsp_data);
      end
      @(negedge clk); f_req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      @(negedge clk);
      f_rsp_ready = 1'b0; f_req_valid = 1'b1; f_req_addr = 64'h0;
      @(posedge clk); #1;
      @(negedge clk);
      f_flush = 1'b1; f_req_addr = 64'h4;
      d_req_valid = 1'b1; d_req_addr = 64'h8;
      #1;
      checks++;
      if (f_req_ready !== 1'b0 || d_req_ready !== 1'b1) begin
         errors++; $display("FAIL flush_ready: got f=%b d=%b expected 0 1", f_req_ready, d_req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (f_rsp_valid !== 1'b0) begin
         errors++; $display("FAIL flush_empty: got v=%b expected 0", f_rsp_valid);
      end
      checks++;
      if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h0020_81b3) begin
         errors++; $display("FAIL flush_data_port: got v=%b d=%h expected 1 002081b3", d_rsp_valid, d_rsp_data);
      end
      @(negedge clk);
      f_flush = 1'b0; f_req_valid = 1'b0; d_req_valid = 1'b0; f_rsp_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      f_rsp_ready = 1'b0; d_rsp_ready = 1'b0;
      d_req_valid = 1'b1; d_req_addr = 64'h4;
      @(posedge clk); #1;
      @(negedge clk);
      d_req_valid = 1'b0; f_req_valid = 1'b1; f_req_addr = 64'h8;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (f_rsp_valid !== 1'b1 || d_rsp_valid !== 1'b1) begin
         errors++; $display("FAIL rstmid_full: got fv=%b dv=%b expected 1 1", f_rsp_valid, d_rsp_valid);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({f_rsp_valid, d_rsp_valid, f_rsp_err, d_rsp_err, f_rsp_data, d_rsp_data} !== '0) begin
         errors++; $display("FAIL rstmid_async: got fv=%b dv=%b fd=%h dd=%h expected all 0",
                            f_rsp_valid, d_rsp_valid, f_rsp_data, d_rsp_data);
      end
      checks++;
      if (f_req_ready !== 1'b0 || mem_addr !== 64'h0) begin
         errors++; $display("FAIL rstmid_ready: got rdy=%b addr=%h expected 0 0", f_req_ready, mem_addr);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; f_rsp_ready = 1'b1; d_rsp_ready = 1'b1; f_req_addr = 64'h0;
      @(posedge clk); #1;
      checks++;
      if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'h0050_0093 || d_rsp_valid !== 1'b0) begin
         errors++; $display("FAIL rstmid_after: got fv=%b fd=%h dv=%b expected 1 00500093 0",
                            f_rsp_valid, f_rsp_data, d_rsp_valid);
      end
      @(negedge clk); f_req_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 32'hA500_0000 | 32'(i);
      rom[0] = 32'h0050_0093;
      rom[1] = 32'h00a0_0113;
      rom[2] = 32'h0020_81b3;
      test_reset();
      test_fetch_only();
      test_starvation();
      test_illegal();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, the requester and memory address width.
REQ-002 SHALL have parameter ROM_WORDS, default 1024, the instruction ROM depth in 32-bit words.
REQ-003 SHALL have parameter STARVE_LIM, default 4, the maximum consecutive data-port grants while fetch waits.
REQ-004 SHALL have ports clk_i in 1 (clock) and rst_i in 1 (reset), with one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port group f_*, the fetch port: f_req_valid_i in 1, f_req_ready_o out 1, f_req_addr_i in ADDR_W, f_flush_i in 1.
REQ-006 SHALL have fetch response ports f_rsp_valid_o out 1, f_rsp_ready_i in 1, f_rsp_data_o out 32, f_rsp_err_o out 1.
REQ-007 SHALL have port group d_*, the data/constant-load port: d_req_valid_i, d_req_ready_o, d_req_addr_i, d_rsp_valid_o, d_rsp_ready_i, d_rsp_data_o, d_rsp_err_o, with widths as for fetch and no flush.
REQ-008 SHALL have ports mem_addr_o out ADDR_W and mem_rdata_i in 32, driving a combinational-read word ROM.

Function
REQ-009 SHALL accept a request on a port when that port's req_valid and req_ready are both high at a rising clk_i edge.
REQ-010 SHALL drive req_ready high for a port only when it wins arbitration this cycle and that port's response slot is empty or is being drained this cycle.
REQ-011 SHALL grant at most one port per cycle.
REQ-012 SHALL use a default priority of data over fetch.
REQ-013 SHALL count consecutive data grants while fetch is valid, eligible and not granted; when the count equals STARVE_LIM, fetch SHALL win the next contended cycle.
REQ-014 SHALL clear the starvation counter on any fetch grant or any cycle without contention; the counter SHALL saturate and never wrap.
REQ-015 SHALL drive mem_addr_o with the granted port's address, and with zero when no port is granted.
REQ-016 SHALL register the response into the winner's slot at the acceptance edge, giving exactly one-cycle latency from accept to rsp_valid high.
REQ-017 SHALL capture rsp_data as mem_rdata_i on a legal access.
REQ-018 SHALL treat an access as illegal when addr[1:0] is not zero or the word index addr[ADDR_W-1:2] is ROM_WORDS or more.
REQ-019 SHALL, on an illegal access, set rsp_err to 1 and rsp_data to 0, and still consume the grant.
REQ-020 SHALL keep each response slot as a 2-state FSM, EMPTY to FULL on accept and FULL to EMPTY on rsp_valid and rsp_ready.
REQ-021 SHALL allow a simultaneous drain and accept on the same port, with the slot staying FULL and loading the new data.
REQ-022 SHALL hold rsp_data and rsp_err stable while rsp_valid is high and rsp_ready is low.
REQ-023 SHALL, on f_flush_i high, empty the fetch slot, suppress any fetch acceptance that cycle, and not reset the starvation counter.
REQ-024 SHALL have no effect on the data port from f_flush_i.
REQ-025 SHALL not combinationally depend on rsp_ready_i for req_ready of the other port.

Reset
REQ-026 SHALL, on rst_i asserted (asynchronous), force both slots EMPTY, all rsp_valid, rsp_data and rsp_err to 0, and the starvation counter to 0.
REQ-027 SHALL drive req_ready low and mem_addr_o to 0 while rst_i is high.
REQ-028 SHALL discard an accepted-but-unreturned response when reset occurs mid-transaction.

Structure
REQ-029 SHALL place the slot-state enum and the default parameter constants in the shared core package.
REQ-030 SHALL instantiate one sub-module, rsp_slot, per port to hold the FSM, data and err.

Verification
REQ-031 Test 1: fetch only at addr 0x0, 0x4, 0x8 with ROM words 0x00500093, 0x00a00113, 0x002081b3 -> these responses arrive one cycle after each accept, with err 0.
REQ-032 Test 2: both ports valid continuously and STARVE_LIM=4 -> grant pattern D,D,D,D,F repeating.
REQ-033 Test 3: d addr 0x2, then d addr 0x1000 -> err 1 and data 0 for both responses.
REQ-034 Test 4: f_rsp_ready low for 3 cycles -> f data held stable, f_req_ready low, and the data port continues to be served.
REQ-035 Test 5: f_flush_i asserted with a fetch slot FULL and a new fetch valid -> slot EMPTY next cycle and no fetch accept that cycle.
REQ-036 Test 6: rst_i asserted mid-cycle between clock edges with both slots FULL -> all outputs 0 immediately, without waiting for a clock edge.
